mem_port_arbiter: RTL

Shares the single-ported 64-bit data/instruction RAM between the instruction-fetch path and the datapath load/store path of the multi-cycle LEGv8 core. Fixed priority goes to the data requester, with an anti-starvation counter that guarantees fetch progress. The block sits between control_unit-driven fetch/memory stages and the RAM macro. It sequences each access through arbitrate, issue, wait and respond phases.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_starve_ctr.sv | 21 ++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant encodings and RAM latency limits for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_IF = 2'd1, GNT_DM = 2'd2} gnt_e;
  localparam int RAM_LAT_MIN = 1;
  localparam int RAM_LAT_MAX = 3;
  localparam int WAIT_W = $clog2(RAM_LAT_MAX);
  function automatic int lat_clamp(input int lat);
    return lat < RAM_LAT_MIN ? RAM_LAT_MIN : lat > RAM_LAT_MAX ? RAM_LAT_MAX : lat;
  endfunction
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of data grants taken while fetch was waiting
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int W = $clog2(STARVE_MAX + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign at_max = cnt_q == W'(STARVE_MAX);
  always_comb cnt_d = clr ? '0 : (inc && !at_max) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit RAM port between fetch and data paths,
// data first, with a starvation counter that forces fetch through
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [63:0]       dm_wdata,
  output logic              dm_ack,
  output logic              dm_err,
  output logic [63:0]       dm_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-4:0] ram_addr,
  output logic [63:0]       ram_wdata,
  input  logic [63:0]       ram_rdata,
  output logic              busy
);
  localparam int LAT = lat_clamp(RAM_LAT);
  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  logic [ADDR_W-1:2] addr_q, addr_d;
  logic              we_q, we_d, err_q, err_d;
  logic [63:0]       wdata_q, wdata_d, dm_rdata_q, dm_rdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic              if_ack_q, if_ack_d, dm_ack_q, dm_ack_d, dm_err_q, dm_err_d, busy_q, busy_d;
  logic              st_inc, st_clr, st_at_max;
  logic              unused_if_lo;

  assign unused_if_lo = ^if_addr[1:0];

  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (st_inc),
    .clr    (st_clr),
    .at_max (st_at_max)
  );

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    err_d = err_q;
    wait_d = wait_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    st_inc = 1'b0;
    st_clr = 1'b0;
    case (state_q)
      IDLE: begin
        st_clr = !if_req;
        if (dm_req && !st_at_max) begin
          gnt_d = GNT_DM;
          addr_d = dm_addr[ADDR_W-1:2];
          we_d = dm_we;
          wdata_d = dm_wdata;
          err_d = |dm_addr[2:0];
          st_inc = if_req;
          state_d = err_d ? RESP : ISSUE;
        end else if (if_req) begin
          gnt_d = GNT_IF;
          addr_d = if_addr[ADDR_W-1:2];
          we_d = 1'b0;
          err_d = 1'b0;
          st_clr = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_d = WAIT_W'(LAT - 1);
        state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == '0) begin
          state_d = RESP;
          if (gnt_q == GNT_IF) if_rdata_d = addr_q[2] ? ram_rdata[63:32] : ram_rdata[31:0];
          else dm_rdata_d = ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    // every output is decided on the transition so it appears registered in the new state
    ram_en_d = state_d == ISSUE;
    ram_we_d = (state_d == ISSUE) && we_d;
    if_ack_d = (state_d == RESP) && (gnt_d == GNT_IF);
    dm_ack_d = (state_d == RESP) && (gnt_d == GNT_DM);
    dm_err_d = (state_d == RESP) && (gnt_d == GNT_DM) && err_d;
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= GNT_NONE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      err_q <= 1'b0;
      wait_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      dm_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      err_q <= err_d;
      wait_q <= wait_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      if_ack_q <= if_ack_d;
      dm_ack_q <= dm_ack_d;
      dm_err_q <= dm_err_d;
      busy_q <= busy_d;
    end
  end

  assign if_ack = if_ack_q;
  assign if_rdata = if_rdata_q;
  assign dm_ack = dm_ack_q;
  assign dm_err = dm_err_q;
  assign dm_rdata = dm_rdata_q;
  assign ram_en = ram_en_q;
  assign ram_we = ram_we_q;
  assign ram_addr = addr_q[ADDR_W-1:3];
  assign ram_wdata = wdata_q;
  assign busy = busy_q;
endmodule
